// File: rtl/sonar_tof.sv
// Sonar time-of-flight engine.
// Fires a transmit burst, blanks the receiver for a programmable number of
// samples, then records the index and magnitude of the first receive sample
// whose magnitude reaches the threshold, or flags a timeout.
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-low reset
//   wbs_*                     Wishbone slave (full-word access, one-cycle ack)
//   smp_valid_i, smp_data_i   signed receive sample stream
//   tx_pulse_o                transmitter drive
//   busy_o                    measurement in progress
//   irq_o                     level interrupt (IRQ_EN & DONE)
module sonar_tof #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned BUS_WIDTH = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_dat_i,
    input  logic [31:0]          wbs_adr_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    input  logic                 smp_valid_i,
    input  logic [BUS_WIDTH-1:0] smp_data_i,
    output logic                 tx_pulse_o,
    output logic                 busy_o,
    output logic                 irq_o
);

    localparam int unsigned CW = 16;
    localparam logic [BUS_WIDTH-1:0] SMP_MIN = {1'b1, {(BUS_WIDTH-1){1'b0}}};
    localparam logic [BUS_WIDTH-1:0] SMP_MAX = ~SMP_MIN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_BLANK,
        S_LISTEN,
        S_FIN
    } state_e;

    state_e          state_q, state_d;
    logic            irq_en_q, irq_en_d;
    logic            cont_q, cont_d;
    logic [CW-1:0]   thresh_q, thresh_d;
    logic [CW-1:0]   blank_q, blank_d;
    logic [CW-1:0]   timeout_q, timeout_d;
    logic [7:0]      plen_q, plen_d;
    logic            done_q, done_d;
    logic            tmo_q, tmo_d;
    logic [31:0]     tof_q, tof_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      pcnt_q, pcnt_d;
    logic            ack_q, ack_d;
    logic [31:0]     rdat_q, rdat_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            irq_q, irq_d;

    logic                 req;
    logic                 start;
    logic [7:0]           off;
    logic [CW-1:0]        cnt_inc;
    logic [CW-1:0]        cnt_n;
    logic [BUS_WIDTH-1:0] mag;
    logic [7:0]           plen_eff;
    logic                 unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_dat_i[31:16]};

    // Next-state, register file and handshake logic.
    always_comb begin
        state_d   = state_q;
        irq_en_d  = irq_en_q;
        cont_d    = cont_q;
        thresh_d  = thresh_q;
        blank_d   = blank_q;
        timeout_d = timeout_q;
        plen_d    = plen_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        tof_d     = tof_q;
        cnt_d     = cnt_q;
        pcnt_d    = pcnt_q;
        rdat_d    = '0;
        start     = 1'b0;
        cnt_n     = cnt_q;

        off     = wbs_adr_i[7:0];
        // A request is never re-acked while its ack is still high.
        req     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
        ack_d   = req;

        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        plen_eff = (plen_q == 8'd0) ? 8'd1 : plen_q;

        // -MIN has no positive counterpart; saturate it.
        if (smp_data_i == SMP_MIN) begin
            mag = SMP_MAX;
        end else if (smp_data_i[BUS_WIDTH-1]) begin
            mag = -smp_data_i;
        end else begin
            mag = smp_data_i;
        end

        if (req && !wbs_we_i) begin
            case (off)
                8'h00:   rdat_d = {29'd0, cont_q, irq_en_q, 1'b0};
                8'h04:   rdat_d = {16'd0, thresh_q};
                8'h08:   rdat_d = {16'd0, blank_q};
                8'h0C:   rdat_d = {16'd0, timeout_q};
                8'h10:   rdat_d = {24'd0, plen_q};
                8'h14:   rdat_d = {29'd0, tmo_q, done_q, busy_q};
                8'h18:   rdat_d = tof_q;
                default: rdat_d = '0;
            endcase
        end

        if (req && wbs_we_i) begin
            case (off)
                8'h00: begin
                    start    = wbs_dat_i[0];
                    irq_en_d = wbs_dat_i[1];
                    cont_d   = wbs_dat_i[2];
                end
                8'h04:   thresh_d  = wbs_dat_i[15:0];
                8'h08:   blank_d   = wbs_dat_i[15:0];
                8'h0C:   timeout_d = wbs_dat_i[15:0];
                8'h10:   plen_d    = wbs_dat_i[7:0];
                8'h14: begin
                    if (wbs_dat_i[1]) done_d = 1'b0;
                    if (wbs_dat_i[2]) tmo_d  = 1'b0;
                end
                default: ;
            endcase
        end

        // Measurement sequencing; hardware status sets follow the W1C above so they win.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_TX;
                    done_d  = 1'b0;
                    tmo_d   = 1'b0;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                end
            end
            S_TX: begin
                cnt_d = '0;
                if ({1'b0, pcnt_q} + 9'd1 >= {1'b0, plen_eff}) begin
                    state_d = S_BLANK;
                end else begin
                    pcnt_d = pcnt_q + 8'd1;
                end
            end
            S_BLANK: begin
                cnt_n = smp_valid_i ? cnt_inc : cnt_q;
                cnt_d = cnt_n;
                if (cnt_n >= blank_q) state_d = S_LISTEN;
            end
            S_LISTEN: begin
                if (smp_valid_i && (CW'(mag) >= thresh_q)) begin
                    tof_d   = {CW'(mag), cnt_q};
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    cnt_n = smp_valid_i ? cnt_inc : cnt_q;
                    cnt_d = cnt_n;
                    if (cnt_n >= timeout_q) begin
                        tof_d   = {16'd0, timeout_q};
                        tmo_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                if (cont_q) begin
                    state_d = S_TX;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        tx_d   = (state_d == S_TX);
        busy_d = (state_d != S_IDLE);
        irq_d  = irq_en_d & done_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q   <= S_IDLE;
            irq_en_q  <= 1'b0;
            cont_q    <= 1'b0;
            thresh_q  <= 16'h0400;
            blank_q   <= 16'd16;
            timeout_q <= 16'd1000;
            plen_q    <= 8'd8;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            tof_q     <= '0;
            cnt_q     <= '0;
            pcnt_q    <= '0;
            ack_q     <= 1'b0;
            rdat_q    <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_en_q  <= irq_en_d;
            cont_q    <= cont_d;
            thresh_q  <= thresh_d;
            blank_q   <= blank_d;
            timeout_q <= timeout_d;
            plen_q    <= plen_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            tof_q     <= tof_d;
            cnt_q     <= cnt_d;
            pcnt_q    <= pcnt_d;
            ack_q     <= ack_d;
            rdat_q    <= rdat_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            irq_q     <= irq_d;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = rdat_q;
    assign tx_pulse_o = tx_q;
    assign busy_o     = busy_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_sonar_tof.sv
// Self-checking bench for sonar_tof: register table, directed measurement
// table, control corner cases and randomized runs against a sample-list model.
module tb_sonar_tof;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [31:0] dat_w, adr, dat_r;
    logic        ack;
    logic        sv;
    logic [15:0] sd;
    logic        tx, busy, irq;

    int checks = 0;
    int errors = 0;
    logic [15:0] smp [0:63];

    always #5 clk = ~clk;

    sonar_tof #(.BASE_ADDR(BASE), .BUS_WIDTH(16)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (4'hF),
        .wbs_dat_i   (dat_w),
        .wbs_adr_i   (adr),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_r),
        .smp_valid_i (sv),
        .smp_data_i  (sd),
        .tx_pulse_o  (tx),
        .busy_o      (busy),
        .irq_o       (irq)
    );

    typedef struct {
        logic [7:0]  off;
        logic [31:0] exp;
    } rv_t;

    typedef struct {
        logic [15:0]  th;
        logic [15:0]  bl;
        logic [15:0]  to;
        logic [7:0]   pl;
        logic [31:0]  ctrl;
        int           n;
        logic [127:0] s;      // sample 0 in the top 16 bits
        logic [31:0]  etof;
        logic [31:0]  estat;
        int           etxc;
    } meas_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [7:0] o, input logic [31:0] d,
                           output logic [31:0] rd);
        stb = 1'b1; cyc = 1'b1; we = w; adr = BASE | 32'(o); dat_w = d;
        @(posedge clk); #1;
        chk("wb_ack", 32'(ack), 32'd1);
        rd = dat_r;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("wb_ack_single", 32'(ack), 32'd0);
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, o, d, dummy);
    endtask

    task automatic rd(input logic [7:0] o, output logic [31:0] v);
        wb_xfer(1'b0, o, 32'd0, v);
    endtask

    task automatic configure(input logic [15:0] th, input logic [15:0] bl,
                             input logic [15:0] to, input logic [7:0] pl);
        wr(8'h04, 32'(th));
        wr(8'h08, 32'(bl));
        wr(8'h0C, 32'(to));
        wr(8'h10, 32'(pl));
    endtask

    // Writes CTRL and counts the transmit pulse that follows immediately.
    task automatic start_run(input logic [31:0] ctrl, output int txc);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE; dat_w = ctrl;
        @(posedge clk); #1;
        chk("start_ack", 32'(ack), 32'd1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        txc = 0;
        for (int g = 0; g < 400 && tx; g++) begin
            txc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic feed(input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                sv = 1'b0;
                @(posedge clk); #1;
            end
            sv = 1'b1; sd = smp[i];
            @(posedge clk); #1;
            sv = 1'b0;
        end
    endtask

    // Called just after the edge that consumed the terminating sample.
    task automatic finish_run(input logic irq_en, input logic [31:0] estat, input logic [31:0] etof);
        logic [31:0] v;
        chk("fin_busy", 32'(busy), 32'd1);
        chk("fin_irq", 32'(irq), 32'(irq_en));
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_tx", 32'(tx), 32'd0);
        rd(8'h14, v);
        chk("status", v, estat);
        rd(8'h18, v);
        chk("tof", v, etof);
        if (irq_en) begin
            wr(8'h14, 32'h2);
            chk("irq_clear", 32'(irq), 32'd0);
        end
    endtask

    function automatic int mag_of(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        if (s == -32768) return 32767;
        return (s < 0) ? -s : s;
    endfunction

    // Reference: walk the sample list by index, skip the blanked ones, stop at
    // the first magnitude >= threshold or when the count reaches the timeout.
    task automatic model(input int th, input int bl, input int to, input int n,
                         output int idx, output logic [31:0] tof, output logic tmo);
        int m;
        idx = -1; tof = '0; tmo = 1'b0;
        for (int i = 0; i < n && idx < 0; i++) begin
            if (i >= bl) begin
                m = mag_of(smp[i]);
                if (m >= th) begin
                    idx = i;
                    tof = {16'(m), 16'(i)};
                end else if (i + 1 >= to) begin
                    idx = i;
                    tmo = 1'b1;
                    tof = 32'(to);
                end
            end
        end
    endtask

    rv_t   rt [9];
    meas_t mt [4];

    initial begin
        logic [31:0] v;
        int txc;

        rt[0] = '{off: 8'h00, exp: 32'h0};
        rt[1] = '{off: 8'h04, exp: 32'h400};
        rt[2] = '{off: 8'h08, exp: 32'd16};
        rt[3] = '{off: 8'h0C, exp: 32'd1000};
        rt[4] = '{off: 8'h10, exp: 32'd8};
        rt[5] = '{off: 8'h14, exp: 32'h0};
        rt[6] = '{off: 8'h18, exp: 32'h0};
        rt[7] = '{off: 8'h1C, exp: 32'h0};
        rt[8] = '{off: 8'h80, exp: 32'h0};

        // Basic detect: 0xFFEC=-20, 0xFF6A=-150
        mt[0] = '{th: 16'd100, bl: 16'd3, to: 16'd1000, pl: 8'd4, ctrl: 32'h3, n: 6,
                  s: {16'h0000, 16'h01F4, 16'h0000, 16'h000A, 16'hFFEC, 16'hFF6A, 16'h0, 16'h0},
                  etof: 32'h0096_0005, estat: 32'h2, etxc: 4};
        // Timeout after the 8th all-zero sample
        mt[1] = '{th: 16'h400, bl: 16'd2, to: 16'd8, pl: 8'd2, ctrl: 32'h1, n: 8,
                  s: 128'd0, etof: 32'h0000_0008, estat: 32'h6, etxc: 2};
        // -32768 saturates; PULSE_LEN=0 behaves as 1
        mt[2] = '{th: 16'h7FFF, bl: 16'd1, to: 16'd1000, pl: 8'd0, ctrl: 32'h3, n: 2,
                  s: {16'h0000, 16'h8000, 96'd0},
                  etof: 32'h7FFF_0001, estat: 32'h2, etxc: 1};
        // Detection on the sample that would time out
        mt[3] = '{th: 16'h7FFF, bl: 16'd2, to: 16'd8, pl: 8'd3, ctrl: 32'h3, n: 8,
                  s: {112'd0, 16'h7FFF},
                  etof: 32'h7FFF_0007, estat: 32'h2, etxc: 3};

        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        adr = '0; dat_w = '0; sv = 1'b0; sd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", dat_r, 32'd0);
        chk("rst_tx", 32'(tx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            rd(rt[i].off, v);
            chk($sformatf("reset_reg_%02h", rt[i].off), v, rt[i].exp);
        end

        wr(8'h04, 32'h1234);
        rd(8'h04, v);
        chk("thresh_rb", v, 32'h1234);
        wr(8'h18, 32'hFFFF_FFFF);
        rd(8'h18, v);
        chk("tof_ro", v, 32'h0);

        // Address outside the block is not acked.
        stb = 1'b1; cyc = 1'b1; adr = BASE + 32'h100;
        @(posedge clk); #1;
        chk("miss_ack0", 32'(ack), 32'd0);
        @(posedge clk); #1;
        chk("miss_ack1", 32'(ack), 32'd0);
        // Held strobe: ack, gap, ack.
        adr = BASE + 32'h4;
        @(posedge clk); #1;
        chk("hold_ack0", 32'(ack), 32'd1);
        @(posedge clk); #1;
        chk("hold_ack1", 32'(ack), 32'd0);
        @(posedge clk); #1;
        chk("hold_ack2", 32'(ack), 32'd1);
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;

        // Directed measurement table.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) smp[i] = mt[t].s[(7 - i) * 16 +: 16];
            configure(mt[t].th, mt[t].bl, mt[t].to, mt[t].pl);
            start_run(mt[t].ctrl, txc);
            chk($sformatf("tbl%0d_txc", t), 32'(txc), 32'(mt[t].etxc));
            feed(0, mt[t].n - 1, 1'b0);
            finish_run(mt[t].ctrl[1], mt[t].estat, mt[t].etof);
        end

        // START while busy is ignored.
        for (int i = 0; i < 8; i++) smp[i] = mt[0].s[(7 - i) * 16 +: 16];
        configure(16'd100, 16'd3, 16'd1000, 8'd4);
        start_run(32'h1, txc);
        feed(0, 0, 1'b0);
        wr(8'h00, 32'h1);
        chk("busy_start_busy", 32'(busy), 32'd1);
        feed(1, 5, 1'b0);
        finish_run(1'b0, 32'h2, 32'h0096_0005);

        // Continuous re-arm, then CONT cleared mid-run.
        smp[0] = 16'd0; smp[1] = 16'd200;
        configure(16'd100, 16'd1, 16'd1000, 8'd3);
        start_run(32'h5, txc);
        chk("cont_txc", 32'(txc), 32'd3);
        feed(0, 1, 1'b0);
        chk("cont_fin_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("cont_retx", 32'(tx), 32'd1);
        wr(8'h00, 32'h0);
        for (int g = 0; g < 400 && tx; g++) begin
            @(posedge clk); #1;
        end
        chk("cont_tx_end", 32'(tx), 32'd0);
        feed(0, 1, 1'b0);
        finish_run(1'b0, 32'h2, 32'h00C8_0001);

        // Reset while listening.
        smp[0] = 16'd0; smp[1] = 16'd5;
        configure(16'd100, 16'd1, 16'd1000, 8'd2);
        start_run(32'h3, txc);
        feed(0, 1, 1'b0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_tx", 32'(tx), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(8'h04, v);
        chk("post_rst_thresh", v, 32'h400);
        rd(8'h00, v);
        chk("post_rst_ctrl", v, 32'h0);
        rd(8'h10, v);
        chk("post_rst_plen", v, 32'd8);

        // Randomized runs against the model.
        for (int r = 0; r < 25; r++) begin
            int th, bl, to, pl, idx, m, k;
            logic [31:0] etof;
            logic etmo, ien;
            th  = int'($urandom_range(20, 3000));
            to  = int'($urandom_range(3, 40));
            bl  = int'($urandom_range(1, to - 1));
            pl  = int'($urandom_range(0, 6));
            ien = 1'($urandom_range(0, 1));
            for (int i = 0; i < to; i++) begin
                k = int'($urandom_range(0, 15));
                if (k == 0) begin
                    smp[i] = 16'h8000;
                end else begin
                    m = (k < 14) ? int'($urandom_range(0, th - 1)) : int'($urandom_range(th, 32767));
                    smp[i] = ($urandom_range(0, 1) == 1) ? 16'(-m) : 16'(m);
                end
            end
            model(th, bl, to, to, idx, etof, etmo);
            configure(16'(th), 16'(bl), 16'(to), 8'(pl));
            start_run({30'd0, ien, 1'b1}, txc);
            chk($sformatf("rnd%0d_txc", r), 32'(txc), (pl == 0) ? 32'd1 : 32'(pl));
            feed(0, idx, 1'b1);
            finish_run(ien, etmo ? 32'h6 : 32'h2, etof);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/sonar_tof.md
Name: sonar_tof

Overview:
- Sonar time-of-flight engine, instantiated directly under the user-project top.
- Fires a transmit burst on a pad and ignores echoes for a programmable blanking window.
- Then compares the magnitude of each incoming 16-bit receive sample against a threshold and records the sample index of the first crossing.
- Configured and read by the management core over Wishbone; raises an interrupt on completion.

Parameters:
- BASE_ADDR, 32'h3000_0000: Wishbone base. The block decodes adr[31:8]==BASE_ADDR[31:8] and uses adr[7:0] as the register offset.
- BUS_WIDTH, 16: receive sample width, signed two's complement.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-low reset. The top drives it from the inverted Caravel reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lanes. Ignored; full-word access only.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- smp_valid_i  in  1  receive sample strobe, one cycle per sample.
- smp_data_i  in  BUS_WIDTH  receive sample.
- tx_pulse_o  out  1  transmitter drive.
- busy_o  out  1  measurement in progress.
- irq_o  out  1  level interrupt, maps to irq[0].

Behaviour:
- Reset values: all outputs 0; FSM state IDLE.
- Register reset values:
  - CTRL = 0
  - THRESH = 0x0400
  - BLANK = 16
  - TIMEOUT = 1000
  - PULSE_LEN = 8
  - STATUS = 0
  - TOF = 0
- Wishbone handshake:
  - A request is wbs_stb_i & wbs_cyc_i & address hit.
  - wbs_ack_o goes high the cycle after a request, for exactly one cycle.
  - A request is not re-acked while ack is high.
  - Read data is registered and valid with ack. Unmapped offsets read 0 and are still acked.
  - Writes to unmapped offsets and to read-only registers are dropped.
- Register map (offset: field):
  - 0x00 CTRL: bit0 START (write 1 = start, self-clears, reads 0); bit1 IRQ_EN; bit2 CONT (continuous re-arm).
  - 0x04 THRESH [15:0].
  - 0x08 BLANK [15:0].
  - 0x0C TIMEOUT [15:0].
  - 0x10 PULSE_LEN [7:0].
  - 0x14 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 TMO (W1C).
  - 0x18 TOF (RO): [15:0] sample index of detection; [31:16] magnitude of the detecting sample.
- FSM states: IDLE, TX, BLANK, LISTEN, FIN.
- IDLE:
  - START=1 -> TX next cycle; clears DONE and TMO; zeros the sample counter.
  - START while not in IDLE is ignored.
- TX:
  - tx_pulse_o=1 for exactly PULSE_LEN cycles (PULSE_LEN=0 treated as 1), then -> BLANK.
  - Samples arriving during TX are ignored and not counted.
- BLANK:
  - Each smp_valid_i increments the counter and is never compared.
  - When counter==BLANK -> LISTEN. BLANK=0 goes straight to LISTEN on the next cycle.
- LISTEN:
  - Per valid sample, mag = |smp_data_i|; -32768 saturates to 32767.
  - mag >= THRESH (unsigned compare): TOF <= {mag, counter}, DONE<=1, -> FIN.
  - Otherwise the counter increments.
  - When counter reaches TIMEOUT with no hit: TMO<=1, DONE<=1, TOF <= {16'h0, TIMEOUT}, -> FIN.
  - A detection on the same sample that would cause timeout wins (TMO stays 0).
- Counter is 16 bits and saturates at 0xFFFF; it never wraps.
- FIN: one cycle, then -> TX if CONT=1, else -> IDLE.
- busy_o = STATUS.BUSY = (state != IDLE).
- irq_o = IRQ_EN & DONE; it drops on the cycle after a W1C to DONE.
- Simultaneous events:
  - Hardware set of DONE wins over a same-cycle W1C.
  - A same-cycle write to THRESH, BLANK or TIMEOUT takes effect on the next sample.
- Reset mid-measurement: immediate return to IDLE, tx_pulse_o=0, all registers to reset values.
- Clearing CONT while running finishes the current measurement, then goes to IDLE.

Test Plan:
- Register access: reset, read all offsets.
  - Expect 0, 0x400, 16, 1000, 8, 0, 0.
  - Write THRESH=0x1234 then read back 0x1234.
  - Each access acks exactly one cycle after stb.
- Basic detect: PULSE_LEN=4, BLANK=3, THRESH=100, START.
  - Feed samples 0,500,0 (blanked), then 10,-20,-150.
  - Expect tx_pulse_o high for exactly 4 cycles.
  - Expect TOF=0x0096_0005, DONE=1, TMO=0.
  - irq_o rises only with IRQ_EN=1; W1C of STATUS bit1 drops it.
- Timeout: TIMEOUT=8, BLANK=2, all-zero samples.
  - Expect DONE=1, TMO=1, TOF=0x0000_0008 after the 8th sample.
- Saturation/edge: THRESH=0x7FFF, sample -32768 -> detect with magnitude field 0x7FFF.
  - Detection on the timeout sample -> TMO=0.
- Control corner cases:
  - START while busy is ignored; TOF is unchanged from the first run.
  - CONT=1 re-enters TX the cycle after FIN.
  - Reset asserted in LISTEN -> IDLE with all outputs 0 on the next edge.
